// File: rtl/uart_tx_fifo.sv
// Byte queue and launch controller feeding a uart_tx serializer.
// Buffers core-side writes and launches one byte per frame over the DV/Active/Done handshake.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Wr_En,
   input  logic [7:0]            i_Wr_Data,
   input  logic                  i_Flush,
   input  logic                  i_Clr_Overflow,
   output logic                  o_Full,
   output logic                  o_Empty,
   output logic [DEPTH_LOG2:0]   o_Count,
   output logic                  o_Overflow,
   output logic                  o_Tx_DV,
   output logic [7:0]            o_Tx_Byte,
   input  logic                  i_Tx_Active,
   input  logic                  i_Tx_Done,
   output logic                  o_Busy
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACTIVE = 2'd1,
      WAIT_DONE   = 2'd2,
      DRAIN       = 2'd3
   } state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count_nxt;
   logic                  wr_ok;
   logic                  pop;
   logic                  ovf_set;

   // Fullness and emptiness come from the registered count, so a same-cycle
   // pop never makes room for a write arriving while full.
   always_comb begin
      wr_ok     = i_Wr_En && !o_Full && !i_Flush;
      pop       = (state == IDLE) && !o_Empty && !i_Flush;
      ovf_set   = i_Wr_En && o_Full && !i_Flush;
      count_nxt = o_Count;
      if (i_Flush) begin
         count_nxt = '0;
      end else if (wr_ok && !pop) begin
         count_nxt = o_Count + 1'b1;
      end else if (pop && !wr_ok) begin
         count_nxt = o_Count - 1'b1;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= i_Wr_Data;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_Count    <= '0;
         o_Empty    <= 1'b1;
         o_Full     <= 1'b0;
         o_Overflow <= 1'b0;
      end else begin
         if (i_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_ok) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
         o_Count <= count_nxt;
         o_Empty <= (count_nxt == '0);
         o_Full  <= (count_nxt == DEPTH_CNT);
         if (ovf_set) begin
            o_Overflow <= 1'b1;
         end else if (i_Clr_Overflow) begin
            o_Overflow <= 1'b0;
         end
      end
   end

   // DRAIN waits for Done to fall so the serializer is back in idle and
   // will actually sample the next DV pulse.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state     <= IDLE;
         o_Tx_DV   <= 1'b0;
         o_Tx_Byte <= 8'h00;
         o_Busy    <= 1'b0;
      end else begin
         o_Tx_DV <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  o_Tx_DV   <= 1'b1;
                  o_Tx_Byte <= mem[rd_ptr];
                  o_Busy    <= 1'b1;
                  state     <= WAIT_ACTIVE;
               end
            end
            WAIT_ACTIVE: begin
               if (i_Tx_Active) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_Tx_Done) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!i_Tx_Done) begin
                  o_Busy <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               o_Busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural serializer on the handshake, transaction-level
// expected-byte stream, directed scenarios plus randomized bursts.
module tb_uart_tx_fifo;

   localparam int DL2   = 4;
   localparam int DEPTH = 16;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_en;
   logic [7:0]     wr_data;
   logic           flush;
   logic           clr_ovf;
   logic           full;
   logic           empty;
   logic [DL2:0]   count;
   logic           overflow;
   logic           tx_dv;
   logic [7:0]     tx_byte;
   logic           tx_active = 1'b0;
   logic           tx_done = 1'b0;
   logic           busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Serializer model state, written only by the negedge process.
   int         ser_phase   = 0;
   logic [7:0] ser_byte    = 8'h00;
   logic       prev_dv     = 1'b0;
   int         dv_bad      = 0;
   int         stable_bad  = 0;
   int         frames_done = 0;
   logic [7:0] dv_bytes[$];

   // Expected launch sequence, written only by the stimulus process.
   logic       ser_stall = 1'b0;
   logic [7:0] exp_tx[$];
   int         chk_idx = 0;

   uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
      .i_Clk          (clk),
      .i_Rst_n        (rst_n),
      .i_Wr_En        (wr_en),
      .i_Wr_Data      (wr_data),
      .i_Flush        (flush),
      .i_Clr_Overflow (clr_ovf),
      .o_Full         (full),
      .o_Empty        (empty),
      .o_Count        (count),
      .o_Overflow     (overflow),
      .o_Tx_DV        (tx_dv),
      .o_Tx_Byte      (tx_byte),
      .i_Tx_Active    (tx_active),
      .i_Tx_Done      (tx_done),
      .o_Busy         (busy)
   );

   always #5 clk = ~clk;

   // Serializer: accepts DV only when idle, runs a 10-bit frame of CPB cycles
   // per bit, then holds Done high for two cycles. Stall freezes it mid-frame.
   always @(negedge clk) begin
      if (!rst_n) begin
         ser_phase = 0;
         tx_active = 1'b0;
         tx_done   = 1'b0;
         prev_dv   = 1'b0;
      end else begin
         if (tx_dv) begin
            dv_bytes.push_back(tx_byte);
            if (prev_dv || ser_phase != 0) dv_bad++;
         end
         prev_dv = tx_dv;
         if (ser_phase == 0) begin
            if (tx_dv) begin
               ser_byte  = tx_byte;
               ser_phase = 1;
               tx_active = 1'b1;
            end
         end else if (ser_phase <= FRAME) begin
            if (!ser_stall) begin
               if (tx_byte !== ser_byte) stable_bad++;
               ser_phase++;
               if (ser_phase > FRAME) begin
                  tx_active = 1'b0;
                  tx_done   = 1'b1;
               end
            end
         end else if (ser_phase == FRAME + 1) begin
            ser_phase++;
         end else begin
            tx_done   = 1'b0;
            ser_phase = 0;
            frames_done++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string tag);
      int k = 0;
      while (!(empty && !busy && ser_phase == 0) && k < limit) begin
         tick();
         k++;
      end
      check({tag, "_idle"}, 32'(empty && !busy && ser_phase == 0), 32'd1);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_len"}, 32'(dv_bytes.size()), 32'(exp_tx.size()));
      for (int i = chk_idx; i < exp_tx.size(); i++) begin
         if (i < dv_bytes.size()) check({tag, "_byte"}, 32'(dv_bytes[i]), 32'(exp_tx[i]));
      end
      chk_idx = exp_tx.size();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_dv"}, 32'(tx_dv), 32'd0);
      check({tag, "_byte"}, 32'(tx_byte), 32'h00);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      int         model_cnt;
      int         f0;
      int         len;
      int         gap;
      logic [7:0] basic_bytes[3];

      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      flush   = 1'b0;
      clr_ovf = 1'b0;
      tick();
      tick();
      check_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      // Launch latency: DV exactly in W+2, for one cycle.
      d = 8'($urandom);
      exp_tx.push_back(d);
      write_byte(d);
      check("lat_w1_count", 32'(count), 32'd1);
      check("lat_w1_dv", 32'(tx_dv), 32'd0);
      tick();
      check("lat_w2_dv", 32'(tx_dv), 32'd1);
      check("lat_w2_byte", 32'(tx_byte), 32'(d));
      check("lat_w2_count", 32'(count), 32'd0);
      tick();
      check("lat_w3_dv", 32'(tx_dv), 32'd0);
      check("lat_w3_busy", 32'(busy), 32'd1);
      wait_idle(200, "lat");
      check_stream("lat");

      // Basic ordering of three consecutive writes.
      basic_bytes[0] = 8'h55;
      basic_bytes[1] = 8'hA3;
      basic_bytes[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         exp_tx.push_back(basic_bytes[i]);
         write_byte(basic_bytes[i]);
      end
      check("basic_count", 32'(count), 32'd2);
      wait_idle(400, "basic");
      check_stream("basic");
      check("basic_empty", 32'(empty), 32'd1);
      check("basic_busy", 32'(busy), 32'd0);

      // Randomized bursts with random gaps; never enough to fill the queue.
      for (int b = 0; b < 5; b++) begin
         len = int'($urandom_range(1, 10));
         for (int j = 0; j < len; j++) begin
            d = 8'($urandom);
            exp_tx.push_back(d);
            write_byte(d);
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
         end
         wait_idle(600, "rand");
         check_stream("rand");
      end

      // Overflow: serializer frozen after the priming byte, so nothing drains.
      ser_stall = 1'b1;
      d = 8'($urandom);
      exp_tx.push_back(d);
      write_byte(d);
      repeat (3) tick();
      model_cnt = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         d = 8'(8'hC0 + i);
         if (model_cnt < DEPTH) begin
            exp_tx.push_back(d);
            model_cnt++;
         end
         write_byte(d);
      end
      check("ovf_count", 32'(count), 32'(DEPTH));
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      clr_ovf = 1'b1;
      tick();
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'd1);
      check("ovf_count18", 32'(count), 32'(DEPTH));
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      ser_stall = 1'b0;
      wait_idle(2000, "ovf");
      check_stream("ovf");

      // Flush with a frame in flight and five bytes queued.
      for (int i = 0; i < 6; i++) begin
         d = 8'(8'h70 + i);
         if (i == 0) exp_tx.push_back(d);
         write_byte(d);
      end
      repeat (10) tick();
      check("flush_pre_count", 32'(count), 32'd5);
      f0      = frames_done;
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h99;
      tick();
      flush   = 1'b0;
      wr_en   = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_ovf", 32'(overflow), 32'd0);
      check("flush_busy", 32'(busy), 32'd1);
      wait_idle(400, "flush");
      repeat (20) tick();
      check("flush_frame_done", 32'(frames_done - f0), 32'd1);
      check_stream("flush");

      // Asynchronous reset mid-frame with four bytes queued.
      for (int i = 0; i < 5; i++) begin
         d = 8'(8'h30 + i);
         if (i == 0) exp_tx.push_back(d);
         write_byte(d);
      end
      check("rst_pre_count", 32'(count), 32'd4);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      tick();
      tick();
      rst_n = 1'b1;
      repeat (60) tick();
      check_stream("rst_quiet");
      d = 8'($urandom);
      exp_tx.push_back(d);
      write_byte(d);
      wait_idle(200, "rst_new");
      check_stream("rst_new");

      // Pointer wrap: 40 incrementing bytes in bursts of ten.
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 10; j++) begin
            d = 8'(b * 10 + j);
            exp_tx.push_back(d);
            write_byte(d);
         end
         wait_idle(800, "wrap");
      end
      check_stream("wrap");

      check("dv_protocol", 32'(dv_bad), 32'd0);
      check("byte_stable", 32'(stable_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
